// File: rtl/uart_cmd_ctrl_pkg.sv
// Shared opcode, reply and FSM state constants for the UART command controller.
package uart_cmd_ctrl_pkg;

   localparam logic [7:0] OP_WR   = 8'h57;
   localparam logic [7:0] OP_RD   = 8'h52;
   localparam logic [7:0] RSP_OK  = 8'h4B;
   localparam logic [7:0] RSP_ERR = 8'h3F;

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_GET_ADDR = 3'd1;
   localparam logic [2:0] ST_GET_DATA = 3'd2;
   localparam logic [2:0] ST_EXEC     = 3'd3;
   localparam logic [2:0] ST_SEND     = 3'd4;

   // Full 8-bit compare; 9 bits so that n=256 is representable.
   function automatic logic addr_in_range(input logic [7:0] addr, input int unsigned n);
      return {1'b0, addr} < 9'(n);
   endfunction

endpackage

// File: rtl/uart_cmd_regfile.sv
// N_REGS x 8-bit register bank: one synchronous write port, one combinational read port.
module uart_cmd_regfile
   import uart_cmd_ctrl_pkg::*;
#(
   parameter int unsigned N_REGS      = 8,
   parameter logic [7:0]  REG_RST_VAL = 8'h00
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                we,
   input  logic [7:0]          addr,
   input  logic [7:0]          din,
   input  logic [7:0]          rd_addr,
   output logic [7:0]          rd_data,
   output logic [N_REGS*8-1:0] regs
);

   logic [7:0] mem_q [N_REGS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(N_REGS); i++) mem_q[i] <= REG_RST_VAL;
      end else if (we) begin
         for (int i = 0; i < int'(N_REGS); i++) begin
            if (addr == 8'(i)) mem_q[i] <= din;
         end
      end
   end

   // Out-of-range reads return zero; the controller replies with an error anyway.
   always_comb begin
      rd_data = '0;
      for (int i = 0; i < int'(N_REGS); i++) begin
         if (rd_addr == 8'(i)) rd_data = mem_q[i];
      end
   end

   for (genvar g = 0; g < int'(N_REGS); g++) begin : g_flat
      assign regs[8*g +: 8] = mem_q[g];
   end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Byte-level 'W'/'R' frame parser between uart_rx and uart_tx, with inter-byte timeout.
module uart_cmd_ctrl
   import uart_cmd_ctrl_pkg::*;
#(
   parameter int unsigned N_REGS         = 8,
   parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
   parameter logic [7:0]  REG_RST_VAL    = 8'h00
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [7:0]          s_axis_tdata,
   input  logic                s_axis_tvalid,
   output logic                s_axis_tready,
   output logic [7:0]          m_axis_tdata,
   output logic                m_axis_tvalid,
   input  logic                m_axis_tready,
   output logic [N_REGS*8-1:0] regs_out,
   output logic                wr_strobe,
   output logic [7:0]          wr_addr,
   output logic                timeout_evt
);

   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);

   logic [2:0]      state_q, state_d;
   logic [7:0]      op_q, addr_q, data_q, rd_data, resp;
   logic            tready_q, tvalid_q, wr_strobe_q, tevt_q;
   logic [7:0]      tdata_q, wr_addr_q;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            accept, expire, cnt_max, waiting;

   assign accept  = s_axis_tvalid & tready_q;
   assign waiting = (state_q == ST_GET_ADDR) || (state_q == ST_GET_DATA);
   assign cnt_max = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

   always_comb begin
      state_d = state_q;
      expire  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = (s_axis_tdata == OP_WR || s_axis_tdata == OP_RD) ? ST_GET_ADDR : ST_EXEC;
            end
         end
         ST_GET_ADDR: begin
            if (accept) state_d = (op_q == OP_WR) ? ST_GET_DATA : ST_EXEC;
            else if (cnt_max) begin
               state_d = ST_IDLE;
               expire  = 1'b1;
            end
         end
         ST_GET_DATA: begin
            if (accept) state_d = ST_EXEC;
            else if (cnt_max) begin
               state_d = ST_IDLE;
               expire  = 1'b1;
            end
         end
         ST_EXEC: state_d = ST_SEND;
         ST_SEND: if (tvalid_q && m_axis_tready) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // An accepted byte beats expiry: the counter clears and no timeout fires.
   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (accept || !waiting || expire) cnt_d = '0;
   end

   always_comb begin
      resp = rd_data;
      if ((op_q != OP_WR && op_q != OP_RD) || !addr_in_range(addr_q, N_REGS)) resp = RSP_ERR;
      else if (op_q == OP_WR) resp = RSP_OK;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         op_q        <= '0;
         addr_q      <= '0;
         data_q      <= '0;
         tready_q    <= 1'b0;
         tvalid_q    <= 1'b0;
         tdata_q     <= '0;
         wr_strobe_q <= 1'b0;
         wr_addr_q   <= '0;
         tevt_q      <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         tready_q    <= (state_d == ST_IDLE) || (state_d == ST_GET_ADDR) ||
                        (state_d == ST_GET_DATA);
         cnt_q       <= cnt_d;
         tevt_q      <= expire;
         wr_strobe_q <= 1'b0;
         if (accept) begin
            case (state_q)
               ST_IDLE:     op_q   <= s_axis_tdata;
               ST_GET_ADDR: addr_q <= s_axis_tdata;
               ST_GET_DATA: begin
                  data_q <= s_axis_tdata;
                  // Strobe lands in the EXEC cycle; the bank updates on the edge ending it.
                  if (addr_in_range(addr_q, N_REGS)) begin
                     wr_strobe_q <= 1'b1;
                     wr_addr_q   <= addr_q;
                  end
               end
               default: ;
            endcase
         end
         if (state_q == ST_EXEC) tdata_q <= resp;
         if (state_q == ST_SEND) begin
            if (!tvalid_q) tvalid_q <= 1'b1;
            else if (m_axis_tready) tvalid_q <= 1'b0;
         end
      end
   end

   uart_cmd_regfile #(
      .N_REGS      (N_REGS),
      .REG_RST_VAL (REG_RST_VAL)
   ) u_regfile (
      .clk     (clk),
      .rst_n   (rst_n),
      .we      (wr_strobe_q),
      .addr    (wr_addr_q),
      .din     (data_q),
      .rd_addr (addr_q),
      .rd_data (rd_data),
      .regs    (regs_out)
   );

   assign s_axis_tready = tready_q;
   assign m_axis_tvalid = tvalid_q;
   assign m_axis_tdata  = tdata_q;
   assign wr_strobe     = wr_strobe_q;
   assign wr_addr       = wr_addr_q;
   assign timeout_evt   = tevt_q;

endmodule
